regfile_alu: RTL and testbench
==============================

Name: regfile_alu

Overview:
- Per-core datapath block: multi-ported register file plus a combinational ALU.
- Sits inside each compute core. The core's control FSM drives register addresses and write-back, and latches the ALU operands.
- The register file is pre-seeded at reset with a per-core base pointer, so cores running identical programs address disjoint data.

Parameters:
- CORE_ID, 0, core index; sets the reset value of the top register.
- DATA_WIDTH, 8, width of registers, ALU operands and result.
- NUM_REGISTERS, 4, register count (>=2); AW = max(1, clog2(NUM_REGISTERS)).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- read_addr1  in  AW  register read port 1 address.
- read_addr2  in  AW  register read port 2 address.
- read_data1  out  DATA_WIDTH  combinational contents of read_addr1.
- read_data2  out  DATA_WIDTH  combinational contents of read_addr2.
- write_en  in  1  register write enable.
- write_addr  in  AW  register write address.
- write_data  in  DATA_WIDTH  register write data.
- alu_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- alu_a  in  DATA_WIDTH  ALU operand A.
- alu_b  in  DATA_WIDTH  ALU operand B.
- alu_result  out  DATA_WIDTH  combinational ALU result.
- alu_zero  out  1  high when alu_result == 0.
- alu_carry  out  1  ADD: carry-out; SUB: borrow (a<b unsigned); AND/OR: 0.
- debug_reg0  out  DATA_WIDTH  combinational copy of R0.

Behaviour:
- Reset (clk edge with reset=1): R0..R(N-2) <= 0; R(N-1) <= CORE_ID*2, truncated to DATA_WIDTH.
  - Reset has priority over a simultaneous write_en.
  - Reset mid-sequence discards any pending write.
- Write: on clk rising edge with reset=0 and write_en=1, R[write_addr] <= write_data.
  - One write per cycle.
  - write_addr >= NUM_REGISTERS: write ignored.
- Read: asynchronous, zero latency, driven from the register array.
  - Same-cycle read of the address being written returns the OLD value; the new value is visible the cycle after the edge (no bypass by default).
  - Read address >= NUM_REGISTERS returns 0.
  - Both ports may read the same register simultaneously.
- debug_reg0 always equals R0, including immediately after reset (0).
- ALU is purely combinational, no state.
  - Result is modulo 2^DATA_WIDTH: ADD wraps, SUB wraps in two's complement.
  - alu_zero and alu_carry are evaluated on the same op as the result.
- No X propagation from uninitialised registers: every register has a defined reset value.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: write-through forwarding. If write_en=1, reset=0 and write_addr (in range) equals a read address, that read port returns write_data in the same cycle. debug_reg0 is also forwarded when write_addr==0.
- Undefined: reads return the stored (old) value as described above.

Decomposition:
- Shared package regfile_alu_pkg holds:
  - alu_op encodings ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - The core opcode encodings LOAD=00, ADD=01, STORE=10, HALT=11.
- One sub-module is natural: regfile_alu_unit, the combinational ALU with flags, instantiated once. Register array and read/write logic stay in the top.

Test Plan:
- Reset with CORE_ID=1, DATA_WIDTH=8 -> R0=R1=R2=0, R3=2, debug_reg0=0. With CORE_ID=0 -> R3=0.
- Write R1=0x05 with write_en=1; in the same cycle read_addr1=1 -> 0x00 (0x05 with RF_BYPASS_EN). Next cycle -> 0x05.
- Write R0=0x11 and R1=0x22, read both ports, drive alu_a/alu_b from them with ADD -> alu_result=0x33, zero=0, carry=0, debug_reg0=0x11.
- ADD 0xFF+0x01 -> result 0x00, zero=1, carry=1. SUB 0x03-0x05 -> result 0xFE, carry=1. AND 0xF0&0x3C -> 0x30. OR -> 0xFC.
- write_en=1 and reset=1 on the same edge with write_addr=2, data=0xAA -> R2=0 after the edge.
- Write to address 3 with data 0x7E, then assert reset mid-sequence -> R3 returns to CORE_ID*2. Subsequent writes resume normally.

Source files
------------

// File: rtl/regfile_alu_pkg.sv
// Shared encodings for the per-core register file / ALU datapath.
package regfile_alu_pkg;

  // ALU operation select driven on alu_op.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  // Core instruction opcodes used by the control FSM that drives this block.
  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    ADD   = 2'b01,
    STORE = 2'b10,
    HALT  = 2'b11
  } core_op_e;

endpackage

// File: rtl/regfile_alu_unit.sv
// Combinational ALU with zero and carry/borrow flags.
// ADD reports carry-out, SUB reports borrow (a < b unsigned), logic ops clear carry.
module regfile_alu_unit
  import regfile_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [1:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_a,
  input  logic [DATA_WIDTH-1:0] alu_b,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_zero,
  output logic                  alu_carry
);

  logic [DATA_WIDTH:0] sum_ext;
  logic [DATA_WIDTH:0] diff_ext;

  // One extra bit on each side exposes carry-out and borrow directly.
  always_comb begin
    sum_ext  = {1'b0, alu_a} + {1'b0, alu_b};
    diff_ext = {1'b0, alu_a} - {1'b0, alu_b};
  end

  // Select result and carry for the requested operation; zero follows the result.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_result = sum_ext[DATA_WIDTH-1:0];
        alu_carry  = sum_ext[DATA_WIDTH];
      end
      ALU_SUB: begin
        alu_result = diff_ext[DATA_WIDTH-1:0];
        alu_carry  = diff_ext[DATA_WIDTH];
      end
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

endmodule

// File: rtl/regfile_alu.sv
// Per-core datapath: register file with two asynchronous read ports and one
// write port, plus the combinational ALU. The top register resets to
// CORE_ID*2 so identical programs on different cores use disjoint data.
// Optional build macro RF_BYPASS_EN: write-through forwarding from the write
// port to both read ports and debug_reg0 in the same cycle.
module regfile_alu
  import regfile_alu_pkg::*;
#(
  parameter  int CORE_ID       = 0,
  parameter  int DATA_WIDTH    = 8,
  parameter  int NUM_REGISTERS = 4,
  localparam int AW            = (NUM_REGISTERS > 2) ? $clog2(NUM_REGISTERS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         read_addr1,
  input  logic [AW-1:0]         read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic                  write_en,
  input  logic [AW-1:0]         write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [1:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_a,
  input  logic [DATA_WIDTH-1:0] alu_b,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_zero,
  output logic                  alu_carry,
  output logic [DATA_WIDTH-1:0] debug_reg0
);

  localparam logic [DATA_WIDTH-1:0] TOP_RST_VAL = DATA_WIDTH'(CORE_ID * 2);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGISTERS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGISTERS];
  logic                  wr_hit;

  // Addresses past the last register are ignored on write and read as zero.
  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) < NUM_REGISTERS);
  endfunction

  // Next register state: reset wins over a write, out-of-range writes drop.
  always_comb begin
    regs_d = regs_q;
    wr_hit = write_en && in_range(write_addr);
    if (reset) begin
      for (int i = 0; i < NUM_REGISTERS; i++) regs_d[i] = '0;
      regs_d[NUM_REGISTERS-1] = TOP_RST_VAL;
    end else if (wr_hit) begin
      regs_d[write_addr] = write_data;
    end
  end

  // Register array update.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Asynchronous reads from the stored array, optionally forwarding the write.
  always_comb begin
    read_data1 = in_range(read_addr1) ? regs_q[read_addr1] : '0;
    read_data2 = in_range(read_addr2) ? regs_q[read_addr2] : '0;
    debug_reg0 = regs_q[0];
`ifdef RF_BYPASS_EN
    if (wr_hit && !reset) begin
      if (write_addr == read_addr1) read_data1 = write_data;
      if (write_addr == read_addr2) read_data2 = write_data;
      if (write_addr == '0)         debug_reg0 = write_data;
    end
`endif
  end

  regfile_alu_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry)
  );

endmodule

// File: tb/tb_regfile_alu.sv
// Directed bench for regfile_alu: reset values for two core IDs, write/read
// timing, ALU ops and flags, reset priority and mid-sequence reset.
module tb_regfile_alu;
  import regfile_alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] read_addr1, read_addr2, write_addr;
  logic       write_en;
  logic [7:0] write_data;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b;

  logic [7:0] rd1, rd2, res, dbg;
  logic       zero, carry;
  logic [7:0] rd1_c0, rd2_c0, res_c0, dbg_c0;
  logic       zero_c0, carry_c0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_alu #(.CORE_ID(1), .DATA_WIDTH(8), .NUM_REGISTERS(4)) dut (
    .clk(clk), .reset(reset),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1), .read_data2(rd2),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(res), .alu_zero(zero), .alu_carry(carry),
    .debug_reg0(dbg)
  );

  regfile_alu #(.CORE_ID(0), .DATA_WIDTH(8), .NUM_REGISTERS(4)) dut_c0 (
    .clk(clk), .reset(reset),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1_c0), .read_data2(rd2_c0),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(res_c0), .alu_zero(zero_c0), .alu_carry(carry_c0),
    .debug_reg0(dbg_c0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    alu_op = op; alu_a = a; alu_b = b;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; write_en = 1'b0; write_addr = 2'd0; write_data = 8'h00;
    read_addr1 = 2'd0; read_addr2 = 2'd1;
    alu_op = ALU_ADD; alu_a = 8'h00; alu_b = 8'h00;
    tick();
    reset = 1'b0;
    #1;

    // Reset values, CORE_ID=1 and CORE_ID=0
    chk("rst_r0", rd1, 8'h00);
    chk("rst_r1", rd2, 8'h00);
    chk("rst_dbg", dbg, 8'h00);
    read_addr1 = 2'd2; read_addr2 = 2'd3; #1;
    chk("rst_r2", rd1, 8'h00);
    chk("rst_r3_core1", rd2, 8'h02);
    chk("rst_r3_core0", rd2_c0, 8'h00);

    // Write R1=0x05: same-cycle read sees old value unless bypassed
    write_en = 1'b1; write_addr = 2'd1; write_data = 8'h05; read_addr1 = 2'd1; #1;
`ifdef RF_BYPASS_EN
    chk("wr_same_cycle", rd1, 8'h05);
`else
    chk("wr_same_cycle", rd1, 8'h00);
`endif
    tick();
    write_en = 1'b0; #1;
    chk("wr_next_cycle", rd1, 8'h05);

    // Write R0=0x11, R1=0x22, then feed ALU from both read ports
    write_en = 1'b1; write_addr = 2'd0; write_data = 8'h11;
    tick();
    write_addr = 2'd1; write_data = 8'h22;
    tick();
    write_en = 1'b0; read_addr1 = 2'd0; read_addr2 = 2'd1; #1;
    chk("rd_r0", rd1, 8'h11);
    chk("rd_r1", rd2, 8'h22);
    chk("dbg_r0", dbg, 8'h11);
    alu(ALU_ADD, rd1, rd2);
    chk("add_res", res, 8'h33);
    chk("add_zero", {7'd0, zero}, 8'h00);
    chk("add_carry", {7'd0, carry}, 8'h00);

    // ALU boundary vectors
    alu(ALU_ADD, 8'hFF, 8'h01);
    chk("add_wrap_res", res, 8'h00);
    chk("add_wrap_zero", {7'd0, zero}, 8'h01);
    chk("add_wrap_carry", {7'd0, carry}, 8'h01);
    alu(ALU_SUB, 8'h03, 8'h05);
    chk("sub_res", res, 8'hFE);
    chk("sub_borrow", {7'd0, carry}, 8'h01);
    chk("sub_zero", {7'd0, zero}, 8'h00);
    alu(ALU_SUB, 8'h05, 8'h05);
    chk("sub_eq_res", res, 8'h00);
    chk("sub_eq_zero", {7'd0, zero}, 8'h01);
    chk("sub_eq_borrow", {7'd0, carry}, 8'h00);
    alu(ALU_SUB, 8'h80, 8'h01);
    chk("sub_nb_res", res, 8'h7F);
    chk("sub_nb_borrow", {7'd0, carry}, 8'h00);
    alu(ALU_AND, 8'hF0, 8'h3C);
    chk("and_res", res, 8'h30);
    chk("and_carry", {7'd0, carry}, 8'h00);
    alu(ALU_OR, 8'hF0, 8'h3C);
    chk("or_res", res, 8'hFC);
    chk("or_carry", {7'd0, carry}, 8'h00);
    alu(ALU_AND, 8'h0F, 8'hF0);
    chk("and_zero", {7'd0, zero}, 8'h01);

    // Reset beats a simultaneous write
    write_en = 1'b1; write_addr = 2'd2; write_data = 8'hAA; reset = 1'b1;
    tick();
    reset = 1'b0; write_en = 1'b0; read_addr1 = 2'd2; read_addr2 = 2'd1; #1;
    chk("rst_prio_r2", rd1, 8'h00);
    chk("rst_prio_r1", rd2, 8'h00);
    chk("rst_prio_dbg", dbg, 8'h00);

    // Write R3=0x7E, reset mid-sequence, then writes resume
    write_en = 1'b1; write_addr = 2'd3; write_data = 8'h7E;
    tick();
    write_en = 1'b0; read_addr1 = 2'd3; read_addr2 = 2'd3; #1;
    chk("r3_written", rd1, 8'h7E);
    chk("r3_written_c0", rd1_c0, 8'h7E);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("r3_rst_core1", rd1, 8'h02);
    chk("r3_rst_core0", rd1_c0, 8'h00);
    write_en = 1'b1; write_addr = 2'd3; write_data = 8'h5A;
    tick();
    write_en = 1'b0; #1;
    chk("r3_resume_p1", rd1, 8'h5A);
    chk("r3_resume_p2", rd2, 8'h5A);
    write_en = 1'b1; write_addr = 2'd0; write_data = 8'hC3;
    tick();
    write_en = 1'b0; read_addr1 = 2'd0; #1;
    chk("r0_resume", rd1, 8'hC3);
    chk("r0_resume_dbg", dbg, 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
